mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sits between the processor's load/store datapath and the word-addressed data RAM. Accepts one byte-addressed load/store request at a time and applies base/limit segment translation for user-mode accesses. Checks alignment and bounds, issues word accesses to the RAM, and returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write.

## Interface
- DATA_WIDTH, 32, data word width (fixed 32; four byte lanes)
- ADDR_WIDTH, 16, byte-address width of requests and segment registers
- MEM_WORDS, 1024, number of RAM words; physical word index must be < MEM_WORDS

- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Req_Valid  in  1  request present
- Req_Ready  out  1  unit can accept; high only in IDLE
- Req_Write  in  1  1 = store, 0 = load
- Req_Size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- Req_Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- Req_Address  in  ADDR_WIDTH  logical byte address
- Req_Data  in  DATA_WIDTH  store data, right-aligned
- Kernel_Mode  in  1  sampled at accept; 1 = bypass translation and limit check
- Seg_Load  in  1  load Seg_Base/Seg_Limit into segment registers
- Seg_Base, Seg_Limit  in  ADDR_WIDTH each  segment base and limit (bytes)
- Resp_Valid  out  1  one-cycle completion pulse
- Resp_Data  out  DATA_WIDTH  formatted load data; 0 for stores and faults
- Fault_Code  out  2  00 ok, 01 misaligned, 10 limit, 11 out of range; valid with Resp_Valid
- Mem_Address  out  ADDR_WIDTH  RAM word index
- Mem_Write_Data  out  DATA_WIDTH  RAM write word
- Mem_Write  out  1  RAM write enable, one cycle per store
- Mem_Read_Data  in  DATA_WIDTH  RAM read word; valid one cycle after Mem_Address is presented

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP, FAULT.
- Accept happens on a Clock edge with state IDLE and Req_Valid=1. At accept, all Req_* fields and Kernel_Mode are latched.
- Translation: physical = logical when Kernel_Mode=1, otherwise logical + Base. The sum is computed ADDR_WIDTH+1 wide.
- Fault checks run at accept, highest priority first:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - Limit: user mode and logical ≥ Limit.
  - Out of range: sum carry-out set, or physical[ADDR_WIDTH-1:2] ≥ MEM_WORDS.
- A faulting request goes to FAULT and never touches memory.
- IDLE: if the request faults, go to FAULT. A word store goes to WRITE. Any load or sub-word store goes to READ.
- READ: Mem_Address = physical>>2, then go to CAPTURE.
- CAPTURE: Mem_Read_Data is registered into the data buffer. A load goes to RESP with formatted data. A sub-word store merges Req_Data into the addressed lane(s) of the buffer, then goes to WRITE.
- WRITE: Mem_Write=1 with the final word, then go to RESP.
- RESP: Resp_Valid=1 and Fault_Code=00, then go to IDLE. FAULT: Resp_Valid=1 with the fault code and Resp_Data=0, then go to IDLE.
- Lanes are little-endian. The byte lane is addr[1:0] (bits 8k+7:8k). The half lane is addr[1]. Untouched lanes are preserved on merge.
- Segment registers: Seg_Load is honoured in any state. A new value affects only requests accepted afterwards, never an in-flight one.
- Seg_Load in the same cycle as accept: the accepted request uses the old values.

## Timing
- Resp_Valid follows the accept edge by:
  - fault: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Req_Ready is low from the cycle after accept until the cycle after RESP/FAULT. There is no back-to-back accept.
- All outputs except Req_Ready come from registers only; no combinational path from Req_* to the Mem_* or Resp_* outputs.
- Reset values:
  - state IDLE, so Req_Ready=1
  - Resp_Valid=0, Resp_Data=0, Fault_Code=00
  - Mem_Address=0, Mem_Write_Data=0, Mem_Write=0
  - Base=0, Limit=0, so every user-mode access limit-faults until Seg_Load
- Reset mid-operation: Mem_Write drops immediately (async). The in-flight request is discarded with no response and no partial write.

## Structure
- Shared package mem_access_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - fault codes FLT_NONE/FLT_ALIGN/FLT_LIMIT/FLT_RANGE
  - the state encoding
- One combinational sub-module, mem_lane_align, does load extract/extend and store lane merge. It takes offset, size, unsigned, the word and the store data.

## Test plan
- Kernel word store 0x12345678 @0x0010, then a word load: Mem_Write pulses once with Mem_Address=4; the load returns 0x12345678 with Fault_Code=00 exactly 3 cycles after accept.
- Byte store 0xAB @0x0011 over word 0x12345678: RAM holds 0x1234AB78. A signed byte load from 0x0011 returns 0xFFFFFFAB; the unsigned load returns 0x000000AB.
- User mode, Base=0x0100, Limit=0x0040:
  - load @0x003C → Mem_Address=0x4F
  - load @0x0040 → Fault_Code=10, no Mem_* activity, Resp_Valid 1 cycle after accept
- Half load @0x0003 with Limit=0 → Fault_Code=01 (misaligned beats limit). Kernel load @0x1000 with MEM_WORDS=1024 → Fault_Code=11.
- Reset asserted during the WRITE of a sub-word store: Mem_Write falls asynchronously, no Resp_Valid; after release, Req_Ready=1 and Base/Limit=0.
- Seg_Load of Base=0x0200 in the accept cycle: the in-flight request uses the old Base; the next request uses 0x0200.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory access unit: bus widths, size and
// fault encodings, and the sequencing state encoding.
package mem_access_pkg;

  localparam int MAU_DATA_WIDTH = 32;
  localparam int MAU_ADDR_WIDTH = 16;
  localparam int MAU_MEM_WORDS  = 1024;

  // Request size encodings; 2'b11 behaves like a word access
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Completion fault codes, reported alongside Resp_Valid
  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_ALIGN = 2'b01;
  localparam logic [1:0] FLT_LIMIT = 2'b10;
  localparam logic [1:0] FLT_RANGE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP,
    ST_FAULT
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and RAM port bundle for the memory access unit.
// The unit itself uses the slave view; the processor/RAM side uses master.
interface mem_access_unit_if
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = MAU_DATA_WIDTH,
  parameter int ADDR_WIDTH = MAU_ADDR_WIDTH
);
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic                  Req_Write;
  logic [1:0]            Req_Size;
  logic                  Req_Unsigned;
  logic [ADDR_WIDTH-1:0] Req_Address;
  logic [DATA_WIDTH-1:0] Req_Data;
  logic                  Resp_Valid;
  logic [DATA_WIDTH-1:0] Resp_Data;
  logic [1:0]            Fault_Code;
  logic [ADDR_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_Write_Data;
  logic                  Mem_Write;
  logic [DATA_WIDTH-1:0] Mem_Read_Data;

  modport slave (
    input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address, Req_Data,
    input  Mem_Read_Data,
    output Req_Ready, Resp_Valid, Resp_Data, Fault_Code,
    output Mem_Address, Mem_Write_Data, Mem_Write
  );

  modport master (
    output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address, Req_Data,
    output Mem_Read_Data,
    input  Req_Ready, Resp_Valid, Resp_Data, Fault_Code,
    input  Mem_Address, Mem_Write_Data, Mem_Write
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a RAM
// word, and merges sub-word store data into a RAM word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, extend it for loads and splice it for stores
  always_comb begin
    byte_v      = word[{offset, 3'b000} +: 8];
    half_v      = word[{offset[1], 4'b0000} +: 16];
    load_data   = word;
    merged_word = store_data;
    case (size)
      SIZE_BYTE: begin
        load_data   = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        merged_word = word;
        merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      end
      SIZE_HALF: begin
        load_data   = {{16{~is_unsigned & half_v[15]}}, half_v};
        merged_word = word;
        merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: begin
        load_data   = word;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: segment translation, alignment and
// bounds checks, word RAM access, load formatting and sub-word RMW stores.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Kernel_Mode,
  input  logic                      Seg_Load,
  input  logic [MAU_ADDR_WIDTH-1:0] Seg_Base,
  input  logic [MAU_ADDR_WIDTH-1:0] Seg_Limit,
  mem_access_unit_if.slave          bus
);

  localparam int AW = MAU_ADDR_WIDTH;
  localparam int DW = MAU_DATA_WIDTH;

  mau_state_e    state_q, state_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          unsigned_q, unsigned_d;
  logic [1:0]    offset_q, offset_d;
  logic [DW-1:0] store_q, store_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] limit_q, limit_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [1:0]    fault_q, fault_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_write_q, mem_write_d;

  logic [AW:0]   phys_sum;
  logic [1:0]    accept_fault;
  logic [DW-1:0] load_data;
  logic [DW-1:0] merged_word;

  mem_lane_align u_align (
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .word        (bus.Mem_Read_Data),
    .store_data  (store_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Translate the incoming address and classify it, highest priority first
  always_comb begin
    phys_sum     = {1'b0, bus.Req_Address} + (Kernel_Mode ? '0 : {1'b0, base_q});
    accept_fault = FLT_NONE;
    if ((bus.Req_Size == SIZE_HALF && bus.Req_Address[0]) ||
        (bus.Req_Size[1] && bus.Req_Address[1:0] != 2'b00)) begin
      accept_fault = FLT_ALIGN;
    end else if (!Kernel_Mode && bus.Req_Address >= limit_q) begin
      accept_fault = FLT_LIMIT;
    end else if (phys_sum[AW] ||
                 32'(phys_sum[AW-1:2]) >= 32'(MAU_MEM_WORDS)) begin
      accept_fault = FLT_RANGE;
    end
  end

  // Next-state and registered-output decode; outputs are loaded for the state being entered
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    offset_d     = offset_q;
    store_d      = store_q;
    base_d       = Seg_Load ? Seg_Base  : base_q;
    limit_d      = Seg_Load ? Seg_Limit : limit_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    fault_d      = FLT_NONE;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Req_Valid) begin
          write_d    = bus.Req_Write;
          size_d     = bus.Req_Size;
          unsigned_d = bus.Req_Unsigned;
          offset_d   = bus.Req_Address[1:0];
          store_d    = bus.Req_Data;
          if (accept_fault != FLT_NONE) begin
            state_d      = ST_FAULT;
            resp_valid_d = 1'b1;
            fault_d      = accept_fault;
          end else if (bus.Req_Write && bus.Req_Size[1]) begin
            state_d     = ST_WRITE;
            mem_addr_d  = {2'b00, phys_sum[AW-1:2]};
            mem_wdata_d = bus.Req_Data;
            mem_write_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            mem_addr_d = {2'b00, phys_sum[AW-1:2]};
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (write_q) begin
          state_d     = ST_WRITE;
          mem_wdata_d = merged_word;
          mem_write_d = 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = load_data;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched request, segment and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      offset_q     <= 2'b00;
      store_q      <= '0;
      base_q       <= '0;
      limit_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      fault_q      <= FLT_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      offset_q     <= offset_d;
      store_q      <= store_d;
      base_q       <= base_d;
      limit_q      <= limit_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      fault_q      <= fault_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign bus.Req_Ready      = (state_q == ST_IDLE);
  assign bus.Resp_Valid     = resp_valid_q;
  assign bus.Resp_Data      = resp_data_q;
  assign bus.Fault_Code     = fault_q;
  assign bus.Mem_Address    = mem_addr_q;
  assign bus.Mem_Write_Data = mem_wdata_q;
  assign bus.Mem_Write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a synchronous RAM model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kernel_mode;
  logic        seg_load;
  logic [15:0] seg_base;
  logic [15:0] seg_limit;
  logic [31:0] ram [0:1023];

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Kernel_Mode (kernel_mode),
    .Seg_Load    (seg_load),
    .Seg_Base    (seg_base),
    .Seg_Limit   (seg_limit),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write on the rising edge
  always @(posedge clk) begin
    if (bus_if.Mem_Write) ram[bus_if.Mem_Address[9:0]] <= bus_if.Mem_Write_Data;
    bus_if.Mem_Read_Data <= ram[bus_if.Mem_Address[9:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request and watch until its response or a cycle budget expires
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [15:0] addr, input logic [31:0] data,
                               input logic kern, input logic segld,
                               output int lat, output logic [31:0] rdata,
                               output logic [1:0] fcode, output int nwr,
                               output logic [15:0] maddr);
    @(negedge clk);
    bus_if.Req_Write    = wr;
    bus_if.Req_Size     = sz;
    bus_if.Req_Unsigned = uns;
    bus_if.Req_Address  = addr;
    bus_if.Req_Data     = data;
    kernel_mode         = kern;
    seg_load            = segld;
    bus_if.Req_Valid    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.Req_Valid = 1'b0;
    seg_load         = 1'b0;
    lat = -1; rdata = '0; fcode = 2'b00; nwr = 0; maddr = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus_if.Mem_Write) nwr++;
      if (bus_if.Resp_Valid) begin
        lat   = n;
        rdata = bus_if.Resp_Data;
        fcode = bus_if.Fault_Code;
        maddr = bus_if.Mem_Address;
        break;
      end
    end
  endtask

  task automatic runCheck(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [15:0] addr, input logic [31:0] data,
                          input logic kern, input logic segld, input int exp_lat,
                          input logic [31:0] exp_data, input logic [1:0] exp_fault,
                          input int exp_nwr, input logic [15:0] exp_maddr);
    int lat, nwr;
    logic [31:0] rdata;
    logic [1:0]  fcode;
    logic [15:0] maddr;
    applyStimulus(wr, sz, uns, addr, data, kern, segld, lat, rdata, fcode, nwr, maddr);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".data"}, rdata, exp_data);
    checkOutput({tag, ".fault"}, {30'b0, fcode}, {30'b0, exp_fault});
    checkOutput({tag, ".writes"}, 32'(nwr), 32'(exp_nwr));
    checkOutput({tag, ".mem_addr"}, {16'b0, maddr}, {16'b0, exp_maddr});
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h04F] = 32'hCAFEF00D;
    ram[10'h040] = 32'h11110000;
    ram[10'h080] = 32'h22220000;
    bus_if.Req_Valid = 1'b0; bus_if.Req_Write = 1'b0; bus_if.Req_Size = SIZE_WORD;
    bus_if.Req_Unsigned = 1'b0; bus_if.Req_Address = '0; bus_if.Req_Data = '0;
    kernel_mode = 1'b1; seg_load = 1'b0; seg_base = '0; seg_limit = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.ready", {31'b0, bus_if.Req_Ready}, 32'd1);
    checkOutput("reset.resp_valid", {31'b0, bus_if.Resp_Valid}, 32'd0);
    checkOutput("reset.resp_data", bus_if.Resp_Data, 32'h0);
    checkOutput("reset.fault", {30'b0, bus_if.Fault_Code}, 32'd0);
    checkOutput("reset.mem_addr", {16'b0, bus_if.Mem_Address}, 32'h0);
    checkOutput("reset.mem_wdata", bus_if.Mem_Write_Data, 32'h0);
    checkOutput("reset.mem_write", {31'b0, bus_if.Mem_Write}, 32'd0);
    rst_n = 1'b1;

    // Kernel word store / load and sub-word RMW on word 4
    runCheck("kws", 1, SIZE_WORD, 0, 16'h0010, 32'h12345678, 1, 0, 2, 32'h0, FLT_NONE, 1, 16'h0004);
    checkOutput("kws.ram", ram[4], 32'h12345678);
    runCheck("kwl", 0, SIZE_WORD, 0, 16'h0010, 32'h0, 1, 0, 3, 32'h12345678, FLT_NONE, 0, 16'h0004);
    runCheck("kbs", 1, SIZE_BYTE, 0, 16'h0011, 32'h000000AB, 1, 0, 4, 32'h0, FLT_NONE, 1, 16'h0004);
    checkOutput("kbs.ram", ram[4], 32'h1234AB78);
    runCheck("sbl", 0, SIZE_BYTE, 0, 16'h0011, 32'h0, 1, 0, 3, 32'hFFFFFFAB, FLT_NONE, 0, 16'h0004);
    runCheck("ubl", 0, SIZE_BYTE, 1, 16'h0011, 32'h0, 1, 0, 3, 32'h000000AB, FLT_NONE, 0, 16'h0004);
    runCheck("khs", 1, SIZE_HALF, 0, 16'h0012, 32'h0000BEEF, 1, 0, 4, 32'h0, FLT_NONE, 1, 16'h0004);
    checkOutput("khs.ram", ram[4], 32'hBEEFAB78);
    runCheck("shl", 0, SIZE_HALF, 0, 16'h0012, 32'h0, 1, 0, 3, 32'hFFFFBEEF, FLT_NONE, 0, 16'h0004);
    runCheck("uhl", 0, SIZE_HALF, 1, 16'h0010, 32'h0, 1, 0, 3, 32'h0000AB78, FLT_NONE, 0, 16'h0004);

    // Faults with reset segment values (Base=0, Limit=0)
    runCheck("ulim0", 0, SIZE_WORD, 0, 16'h0000, 32'h0, 0, 0, 1, 32'h0, FLT_LIMIT, 0, 16'h0004);
    runCheck("umis", 0, SIZE_HALF, 0, 16'h0003, 32'h0, 0, 0, 1, 32'h0, FLT_ALIGN, 0, 16'h0004);
    runCheck("kmisw", 0, SIZE_WORD, 0, 16'h0002, 32'h0, 1, 0, 1, 32'h0, FLT_ALIGN, 0, 16'h0004);
    runCheck("krange", 0, SIZE_WORD, 0, 16'h1000, 32'h0, 1, 0, 1, 32'h0, FLT_RANGE, 0, 16'h0004);
    runCheck("kstrange", 1, SIZE_WORD, 0, 16'h1000, 32'h5, 1, 0, 1, 32'h0, FLT_RANGE, 0, 16'h0004);

    // User segment Base=0x0100, Limit=0x0040
    @(negedge clk);
    seg_base = 16'h0100; seg_limit = 16'h0040; seg_load = 1'b1;
    @(negedge clk);
    seg_load = 1'b0;
    runCheck("useg", 0, SIZE_WORD, 0, 16'h003C, 32'h0, 0, 0, 3, 32'hCAFEF00D, FLT_NONE, 0, 16'h004F);
    runCheck("ulim", 0, SIZE_WORD, 0, 16'h0040, 32'h0, 0, 0, 1, 32'h0, FLT_LIMIT, 0, 16'h004F);

    // Segment reload coinciding with accept: old base for this one, new base next
    seg_base = 16'h0200;
    runCheck("seg_old", 0, SIZE_WORD, 0, 16'h0000, 32'h0, 0, 1, 3, 32'h11110000, FLT_NONE, 0, 16'h0040);
    runCheck("seg_new", 0, SIZE_WORD, 0, 16'h0000, 32'h0, 0, 0, 3, 32'h22220000, FLT_NONE, 0, 16'h0080);

    // Reset during the write phase of a sub-word store
    @(negedge clk);
    bus_if.Req_Write = 1'b1; bus_if.Req_Size = SIZE_BYTE; bus_if.Req_Unsigned = 1'b0;
    bus_if.Req_Address = 16'h0011; bus_if.Req_Data = 32'h00000055; kernel_mode = 1'b1;
    bus_if.Req_Valid = 1'b1;
    @(posedge clk);
    #1 bus_if.Req_Valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.write_before", {31'b0, bus_if.Mem_Write}, 32'd1);
    checkOutput("rst.wdata", bus_if.Mem_Write_Data, 32'hBEEF5578);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.write_drop", {31'b0, bus_if.Mem_Write}, 32'd0);
    checkOutput("rst.ready", {31'b0, bus_if.Req_Ready}, 32'd1);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.Resp_Valid) seen++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.Resp_Valid) seen++;
    end
    checkOutput("rst.no_resp", 32'(seen), 32'd0);
    checkOutput("rst.ram", ram[4], 32'hBEEFAB78);
    checkOutput("rst.ready_after", {31'b0, bus_if.Req_Ready}, 32'd1);
    runCheck("rst.seg", 0, SIZE_WORD, 0, 16'h0000, 32'h0, 0, 0, 1, 32'h0, FLT_LIMIT, 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
